pattern_ram_arbiter: RTL and testbench
======================================

Name: pattern_ram_arbiter

Overview:
- Shared pattern RAM that sits directly upstream of the DAC function generator.
- Caravel firmware loads 32-bit pattern words into it over the Caravel Wishbone bus.
- The generator's RAMBus master reads those words back over an 8-bit-address Wishbone port.
- One single-port memory array is shared by both ports; a round-robin arbiter grants one access per grant cycle.

Parameters:
- BASE_ADDRESS, 32'h3000_0100: Caravel byte address of RAM word 0; word i lives at BASE_ADDRESS + 4*i.
- DEPTH, 256: number of 32-bit words; legal values 2..256.
- ADDR_W, 8: internal word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- caravel_wb_clk_i  in  1  system clock; also clocks the RAMBus side (same clock domain).
- caravel_wb_rst_i  in  1  asynchronous, active-high reset.
- caravel_wb_stb_i  in  1  Caravel strobe.
- caravel_wb_cyc_i  in  1  Caravel cycle.
- caravel_wb_we_i  in  1  Caravel write enable.
- caravel_wb_sel_i  in  4  Caravel byte lane select.
- caravel_wb_dat_i  in  32  Caravel write data.
- caravel_wb_addr_i  in  32  Caravel byte address.
- caravel_wb_ack_o  out  1  Caravel ack.
- caravel_wb_dat_o  out  32  Caravel read data.
- rambus_wb_stb_i  in  1  generator strobe.
- rambus_wb_cyc_i  in  1  generator cycle.
- rambus_wb_we_i  in  1  generator write enable (the generator drives 0; writes are still honoured).
- rambus_wb_sel_i  in  4  generator byte lane select.
- rambus_wb_dat_i  in  32  generator write data.
- rambus_wb_addr_i  in  8  generator word address.
- rambus_wb_ack_o  out  1  generator ack.
- rambus_wb_dat_o  out  32  generator read data.

Behaviour:
- Reset (async assert, sync release):
  - both ack_o = 0; both dat_o = 0; state = IDLE; last_grant = CARAVEL, so RAMBus wins the first tie.
  - Memory contents are not reset.
- Caravel request: stb & cyc & BASE_ADDRESS <= addr < BASE_ADDRESS + 4*DEPTH.
  - Word index = (addr - BASE_ADDRESS) >> 2; addr[1:0] ignored.
  - Out-of-window addresses are never acked; another peripheral owns them.
- RAMBus request: stb & cyc. Every address is acked.
  - addr >= DEPTH: a read returns 32'h0; a write is dropped.
- FSM states: IDLE, ACK_CARAVEL, ACK_RAMBUS.
  - IDLE, only one port requesting: grant that port.
  - IDLE, both requesting: grant the port that is not last_grant.
  - On grant, at the same edge: perform the memory access; register dat_o; set that port's ack_o = 1; update last_grant; go to the matching ACK state.
  - ACK_x: ack_o returns to 0 at the next edge; go to IDLE. No request is sampled in an ACK state, so a master that drops stb the cycle after ack is never double-served.
- Latency:
  - Request sampled at edge N; ack_o and dat_o valid during cycle N+1; ack is a 1-cycle pulse.
  - Single-port throughput: 1 access per 2 cycles.
  - Contended throughput: strict alternation; the worst-case wait for either port is 2 cycles.
- Writes:
  - Each byte lane k is updated only where sel[k] = 1.
  - Write ack: dat_o holds its previous value.
- Read-after-write: a read granted after a write's ack returns the new data. No bypass is needed, since accesses are serialized.
- Simultaneous requests to the same word: serialized by the grant order; no merge.
- A request withdrawn (stb low) before grant is simply not served; no ack.
- Reset mid-ACK: ack drops asynchronously; a write already committed at the grant edge stays committed.

Decomposition:
- Package pattern_ram_pkg:
  - FSM state encoding (IDLE = 0, ACK_CARAVEL = 1, ACK_RAMBUS = 2);
  - grant-id constants (GRANT_CARAVEL, GRANT_RAMBUS);
  - default DEPTH / ADDR_W.
- Sub-module pattern_ram_core:
  - DEPTH x 32 single-port array;
  - inputs en, we, sel[3:0], addr[ADDR_W-1:0], wdata[31:0]; output rdata[31:0];
  - synchronous read, byte-lane write.
- The arbiter and FSM stay in pattern_ram_arbiter.

Test Plan:
- Caravel write 32'hDEAD_BEEF to 0x3000_0104, sel=4'hF, then Caravel read of the same address -> ack one cycle after each request; read data = 32'hDEAD_BEEF.
- Caravel writes words 0..3 = 32'h0403_0201, 0x0807_0605, ...; RAMBus reads addr 0,1,2,3 with a generator-style handshake (stb dropped after ack) -> dat_o equals each word; exactly one ack per request.
- Both ports assert stb at the same edge right after reset -> RAMBus acked first at N+1, Caravel acked at N+3. Hold both requesting continuously -> grants alternate.
- Byte lanes: word 5 = 32'h1122_3344, then Caravel write 32'hAABB_CCDD with sel=4'b0101 -> word 5 reads 32'h11BB_33DD.
- Out-of-range requests:
  - Caravel read at 0x3000_0000 -> no ack for 10 cycles; state stays IDLE.
  - With DEPTH=16, RAMBus read addr 20 -> ack with 32'h0.
- Assert reset while ack_o = 1 -> ack_o and dat_o go to 0 immediately. After release, a previously written word still reads back its old value.

Source files
------------

// File: rtl/pattern_ram_pkg.sv
// Shared types and defaults for the pattern RAM and its two-port arbiter.
package pattern_ram_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned SEL_W          = 4;
  localparam int unsigned DEFAULT_DEPTH  = 256;
  localparam int unsigned DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACK_CARAVEL = 2'd1,
    ACK_RAMBUS  = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_CARAVEL = 1'b0,
    GRANT_RAMBUS  = 1'b1
  } grant_e;

  // Write-side payload of one memory access, as selected by the arbiter.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/pattern_ram_core.sv
// Single-port DEPTH x 32 pattern array: synchronous read, byte-lane write.
module pattern_ram_core
  import pattern_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = addr[IDX_W-1:0];

  // rdata only moves on reads, so it keeps the last read word across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < int'(SEL_W); k++) begin
          if (sel[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/pattern_ram_arbiter.sv
// Pattern RAM shared by Caravel Wishbone (loader) and the generator's RAMBus
// (reader); round-robin grant, one access per grant/ack pair.
module pattern_ram_arbiter
  import pattern_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_addr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  input  logic        rambus_wb_stb_i,
  input  logic        rambus_wb_cyc_i,
  input  logic        rambus_wb_we_i,
  input  logic [3:0]  rambus_wb_sel_i,
  input  logic [31:0] rambus_wb_dat_i,
  input  logic [7:0]  rambus_wb_addr_i,
  output logic        rambus_wb_ack_o,
  output logic [31:0] rambus_wb_dat_o
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic clk;
  logic rst;
  assign clk = caravel_wb_clk_i;
  assign rst = caravel_wb_rst_i;

  state_e state_q, state_d;
  grant_e last_q, last_d;
  logic   grant_cav, grant_rb;

  logic              cav_req, rb_req, rb_in_range;
  logic [29:0]       cav_word;
  logic              unused_addr_lsb;
  mem_req_t          mem_req;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] core_rdata;

  logic              rd_q, oob_q;
  logic [DATA_W-1:0] cav_hold_q, rb_hold_q;
  logic [DATA_W-1:0] rb_rdata_c;

  // Byte offset bits never select anything; the window is word-granular.
  assign unused_addr_lsb = ^caravel_wb_addr_i[1:0];
  assign cav_word        = caravel_wb_addr_i[31:2] - BASE_ADDRESS[31:2];
  assign cav_req         = caravel_wb_stb_i & caravel_wb_cyc_i
                         & (caravel_wb_addr_i >= BASE_ADDRESS)
                         & ({2'b00, cav_word} < DEPTH_W);
  assign rb_req          = rambus_wb_stb_i & rambus_wb_cyc_i;
  assign rb_in_range     = 32'(rambus_wb_addr_i) < DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_CARAVEL;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Requests are only looked at in IDLE; a tie goes to whoever was not served last.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_cav = 1'b0;
    grant_rb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cav_req && (!rb_req || last_q == GRANT_RAMBUS)) begin
          grant_cav = 1'b1;
          state_d   = ACK_CARAVEL;
          last_d    = GRANT_CARAVEL;
        end else if (rb_req) begin
          grant_rb  = 1'b1;
          state_d   = ACK_RAMBUS;
          last_d    = GRANT_RAMBUS;
        end
      end
      ACK_CARAVEL, ACK_RAMBUS: state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = '{we: rambus_wb_we_i, sel: rambus_wb_sel_i, wdata: rambus_wb_dat_i};
    mem_addr = ADDR_W'(rambus_wb_addr_i);
    if (grant_cav) begin
      mem_req  = '{we: caravel_wb_we_i, sel: caravel_wb_sel_i, wdata: caravel_wb_dat_i};
      mem_addr = cav_word[ADDR_W-1:0];
    end
  end

  // Out-of-range RAMBus accesses never touch the array.
  assign mem_en = grant_cav | (grant_rb & rb_in_range);

  pattern_ram_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_req.we),
    .sel   (mem_req.sel),
    .addr  (mem_addr),
    .wdata (mem_req.wdata),
    .rdata (core_rdata)
  );

  // Per-port hold registers keep dat_o stable after the ack and through write acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= 1'b0;
      oob_q      <= 1'b0;
      cav_hold_q <= '0;
      rb_hold_q  <= '0;
    end else begin
      if (grant_cav || grant_rb) begin
        rd_q  <= ~mem_req.we;
        oob_q <= grant_rb & ~rb_in_range;
      end
      if (state_q == ACK_CARAVEL && rd_q) cav_hold_q <= core_rdata;
      if (state_q == ACK_RAMBUS && rd_q)  rb_hold_q  <= rb_rdata_c;
    end
  end

  assign rb_rdata_c       = oob_q ? '0 : core_rdata;
  assign caravel_wb_ack_o = (state_q == ACK_CARAVEL);
  assign rambus_wb_ack_o  = (state_q == ACK_RAMBUS);
  assign caravel_wb_dat_o = (state_q == ACK_CARAVEL && rd_q) ? core_rdata : cav_hold_q;
  assign rambus_wb_dat_o  = (state_q == ACK_RAMBUS && rd_q)  ? rb_rdata_c : rb_hold_q;

endmodule

// File: tb/tb_pattern_ram_arbiter.sv
// Self-checking bench for pattern_ram_arbiter: transaction model plus directed vectors.
module tb_pattern_ram_arbiter;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_stb = 1'b0, c_cyc = 1'b0, c_we = 1'b0;
  logic [3:0]  c_sel = '0;
  logic [31:0] c_din = '0, c_addr = '0;
  logic        c_ack;
  logic [31:0] c_dout;
  logic        r_stb = 1'b0, r_cyc = 1'b0, r_we = 1'b0;
  logic [3:0]  r_sel = '0;
  logic [31:0] r_din = '0;
  logic [7:0]  r_addr = '0;
  logic        r_ack;
  logic [31:0] r_dout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pattern_ram_arbiter #(
    .BASE_ADDRESS (BASE),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W)
  ) dut (
    .caravel_wb_clk_i  (clk),
    .caravel_wb_rst_i  (rst),
    .caravel_wb_stb_i  (c_stb),
    .caravel_wb_cyc_i  (c_cyc),
    .caravel_wb_we_i   (c_we),
    .caravel_wb_sel_i  (c_sel),
    .caravel_wb_dat_i  (c_din),
    .caravel_wb_addr_i (c_addr),
    .caravel_wb_ack_o  (c_ack),
    .caravel_wb_dat_o  (c_dout),
    .rambus_wb_stb_i   (r_stb),
    .rambus_wb_cyc_i   (r_cyc),
    .rambus_wb_we_i    (r_we),
    .rambus_wb_sel_i   (r_sel),
    .rambus_wb_dat_i   (r_din),
    .rambus_wb_addr_i  (r_addr),
    .rambus_wb_ack_o   (r_ack),
    .rambus_wb_dat_o   (r_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory with per-byte known mask; a served port blocks the next edge.
  logic [31:0] m_mem   [DEPTH] = '{default: '0};
  logic [31:0] m_known [DEPTH] = '{default: '0};
  bit          m_busy, m_last_r, c_want, r_want, pick_r;
  int          m_idx;
  bit          e_ack_c, e_ack_r;
  logic [31:0] e_dat_c, e_dat_r, e_msk_c, e_msk_r;

  task automatic m_write(input int idx, input logic [3:0] sel, input logic [31:0] wd);
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) begin
        m_mem[idx][8*k +: 8]   = wd[8*k +: 8];
        m_known[idx][8*k +: 8] = 8'hFF;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_last_r = 0; e_ack_c = 0; e_ack_r = 0;
      e_dat_c = '0; e_dat_r = '0; e_msk_c = '1; e_msk_r = '1;
    end else begin
      e_ack_c = 0;
      e_ack_r = 0;
      if (m_busy) begin
        m_busy = 0;
      end else begin
        c_want = c_stb && c_cyc && (c_addr >= BASE) && (c_addr < BASE + 32'(4 * DEPTH));
        r_want = r_stb && r_cyc;
        if (c_want || r_want) begin
          pick_r   = r_want && (!c_want || !m_last_r);
          m_busy   = 1;
          m_last_r = pick_r;
          if (pick_r) begin
            e_ack_r = 1;
            if (r_addr < 8'(DEPTH)) begin
              m_idx = int'(r_addr);
              if (r_we) m_write(m_idx, r_sel, r_din);
              else begin e_dat_r = m_mem[m_idx]; e_msk_r = m_known[m_idx]; end
            end else if (!r_we) begin
              e_dat_r = '0; e_msk_r = '1;
            end
          end else begin
            e_ack_c = 1;
            m_idx = int'((c_addr - BASE) / 4);
            if (c_we) m_write(m_idx, c_sel, c_din);
            else begin e_dat_c = m_mem[m_idx]; e_msk_c = m_known[m_idx]; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc ack_caravel", 32'(c_ack), 32'(e_ack_c));
      chk("cyc ack_rambus", 32'(r_ack), 32'(e_ack_r));
      chk("cyc dat_caravel", c_dout & e_msk_c, e_dat_c & e_msk_c);
      chk("cyc dat_rambus", r_dout & e_msk_r, e_dat_r & e_msk_r);
    end
  end

  task automatic cav_wait(output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (c_ack) begin lat = i; rd = c_dout; end
    end
    c_stb = 0; c_cyc = 0; c_we = 0;
    @(posedge clk);
  endtask

  task automatic rb_wait(output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (r_ack) begin lat = i; rd = r_dout; end
    end
    r_stb = 0; r_cyc = 0; r_we = 0;
    @(posedge clk);
  endtask

  task automatic cav_xfer(input logic we, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int lat, output logic [31:0] rd);
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = we; c_addr = a; c_sel = s; c_din = d;
    cav_wait(lat, rd);
  endtask

  task automatic rb_xfer(input logic we, input logic [7:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
    @(negedge clk);
    r_stb = 1; r_cyc = 1; r_we = we; r_addr = a; r_sel = s; r_din = d;
    rb_wait(lat, rd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lc, lr, n_c, n_r, prev, first, alt_err, extra;
    logic [31:0] dc, dr, w;

    repeat (2) @(posedge clk);
    #1;
    chk("reset ack_caravel", 32'(c_ack), 32'd0);
    chk("reset ack_rambus", 32'(r_ack), 32'd0);
    chk("reset dat_caravel", c_dout, 32'd0);
    chk("reset dat_rambus", r_dout, 32'd0);
    @(negedge clk);
    rst = 0;

    // Tie right after reset: RAMBus first, Caravel two cycles later.
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = 0; c_addr = 32'h3000_0104;
    r_stb = 1; r_cyc = 1; r_we = 0; r_addr = 8'd0;
    fork
      cav_wait(lc, dc);
      rb_wait(lr, dr);
    join
    chk("tie rambus latency", 32'(lr), 32'd1);
    chk("tie caravel latency", 32'(lc), 32'd3);

    cav_xfer(1, 32'h3000_0104, 4'hF, 32'hDEAD_BEEF, lc, dc);
    chk("write latency", 32'(lc), 32'd1);
    cav_xfer(0, 32'h3000_0104, 4'hF, 32'h0, lc, dc);
    chk("read latency", 32'(lc), 32'd1);
    chk("read deadbeef", dc, 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) begin
      w = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      cav_xfer(1, BASE + 32'(4*i), 4'hF, w, lc, dc);
    end
    for (int i = 0; i < 4; i++) begin
      w = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      rb_xfer(0, 8'(i), 4'hF, 32'h0, lr, dr);
      chk("rambus read data", dr, w);
      chk("rambus read latency", 32'(lr), 32'd1);
      extra = 0;
      repeat (3) begin @(posedge clk); #1; if (r_ack) extra++; end
      chk("rambus single ack", 32'(extra), 32'd0);
    end
    rb_xfer(0, 8'd3, 4'hF, 32'h0, lr, dr);
    chk("rambus word3 literal", dr, 32'h100F_0E0D);

    cav_xfer(1, 32'h3000_0114, 4'hF, 32'h1122_3344, lc, dc);
    cav_xfer(1, 32'h3000_0114, 4'b0101, 32'hAABB_CCDD, lc, dc);
    cav_xfer(0, 32'h3000_0114, 4'hF, 32'h0, lc, dc);
    chk("byte lanes", dc, 32'h11BB_33DD);

    // Both held continuously: grants must alternate, RAMBus first.
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = 0; c_addr = 32'h3000_0104;
    r_stb = 1; r_cyc = 1; r_we = 0; r_addr = 8'd0;
    n_c = 0; n_r = 0; prev = 0; first = 0; alt_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (c_ack) begin n_c++; if (prev == 1) alt_err++; if (first == 0) first = 1; prev = 1; end
      if (r_ack) begin n_r++; if (prev == 2) alt_err++; if (first == 0) first = 2; prev = 2; end
    end
    c_stb = 0; c_cyc = 0; r_stb = 0; r_cyc = 0;
    @(posedge clk);
    chk("alt caravel acks", 32'(n_c), 32'd3);
    chk("alt rambus acks", 32'(n_r), 32'd3);
    chk("alt no repeats", 32'(alt_err), 32'd0);
    chk("alt rambus first", 32'(first), 32'd2);

    cav_xfer(1, 32'h3000_013C, 4'hF, 32'h0F0F_F0F0, lc, dc);
    cav_xfer(0, 32'h3000_013C, 4'hF, 32'h0, lc, dc);
    chk("last word", dc, 32'h0F0F_F0F0);

    // Caravel below the window: never acked, arbiter stays free for RAMBus.
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = 0; c_addr = 32'h3000_0000;
    n_c = 0;
    repeat (10) begin @(posedge clk); #1; if (c_ack) n_c++; end
    chk("caravel below window", 32'(n_c), 32'd0);
    rb_xfer(0, 8'd3, 4'hF, 32'h0, lr, dr);
    chk("idle during oob latency", 32'(lr), 32'd1);
    chk("idle during oob data", dr, 32'h100F_0E0D);
    @(negedge clk);
    c_addr = 32'h3000_0140;
    n_c = 0;
    repeat (4) begin @(posedge clk); #1; if (c_ack) n_c++; end
    chk("caravel past window", 32'(n_c), 32'd0);
    c_stb = 0; c_cyc = 0;

    cav_xfer(1, 32'h3000_0110, 4'hF, 32'h4444_5555, lc, dc);
    rb_xfer(0, 8'd20, 4'hF, 32'h0, lr, dr);
    chk("rambus oob latency", 32'(lr), 32'd1);
    chk("rambus oob data", dr, 32'h0);
    rb_xfer(1, 8'd20, 4'hF, 32'hFFFF_FFFF, lr, dr);
    chk("rambus oob write ack", 32'(lr), 32'd1);
    rb_xfer(0, 8'd4, 4'hF, 32'h0, lr, dr);
    chk("oob write dropped", dr, 32'h4444_5555);
    rb_xfer(0, 8'd15, 4'hF, 32'h0, lr, dr);
    chk("rambus last word", dr, 32'h0F0F_F0F0);

    // Reset during a read ack.
    cav_xfer(1, 32'h3000_0118, 4'hF, 32'hCAFE_F00D, lc, dc);
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = 0; c_addr = 32'h3000_0118;
    @(posedge clk); #1;
    chk("pre-reset ack", 32'(c_ack), 32'd1);
    chk("pre-reset data", c_dout, 32'hCAFE_F00D);
    rst = 1;
    #1;
    chk("mid-ack reset ack_caravel", 32'(c_ack), 32'd0);
    chk("mid-ack reset dat_caravel", c_dout, 32'd0);
    chk("mid-ack reset ack_rambus", 32'(r_ack), 32'd0);
    chk("mid-ack reset dat_rambus", r_dout, 32'd0);
    c_stb = 0; c_cyc = 0;
    @(negedge clk);
    rst = 0;

    // Reset during a write ack: the write already landed.
    @(negedge clk);
    c_stb = 1; c_cyc = 1; c_we = 1; c_addr = 32'h3000_011C; c_sel = 4'hF; c_din = 32'h5A5A_A5A5;
    @(posedge clk); #1;
    chk("pre-reset write ack", 32'(c_ack), 32'd1);
    rst = 1;
    #1;
    chk("write-ack reset ack", 32'(c_ack), 32'd0);
    c_stb = 0; c_cyc = 0; c_we = 0;
    @(negedge clk);
    rst = 0;

    cav_xfer(0, 32'h3000_011C, 4'hF, 32'h0, lc, dc);
    chk("committed write kept", dc, 32'h5A5A_A5A5);
    cav_xfer(0, 32'h3000_0118, 4'hF, 32'h0, lc, dc);
    chk("memory survives reset", dc, 32'hCAFE_F00D);
    rb_xfer(0, 8'd4, 4'hF, 32'h0, lr, dr);
    chk("rambus after reset", dr, 32'h4444_5555);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
